// File: rtl/mult_timing_monitor.sv
// ============================================================================
// Module   : mult_timing_monitor
// Purpose  : Cycle-accurate latency checker for a dual-copy constant-time
//            multiplier; reports per-run latencies, leak, sticky leak, timeout.
//            Optional product comparison enabled by MULT_PRODUCT_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_timing_monitor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               product_done_a,
  input  logic               product_done_b,
  input  logic [2*WIDTH-1:0] product_a,
  input  logic [2*WIDTH-1:0] product_b,
  output logic               busy,
  output logic               result_valid,
  output logic [CNT_W-1:0]   latency_a,
  output logic [CNT_W-1:0]   latency_b,
  output logic               leak,
  output logic               leak_sticky,
  output logic               timeout,
  output logic               product_mismatch
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt_a, r_cnt_b;
  logic               r_done_a, r_done_b;
  logic               r_busy, r_result_valid;
  logic [CNT_W-1:0]   r_latency_a, r_latency_b;
  logic               r_leak, r_leak_sticky, r_timeout, r_product_mismatch;

  logic [CNT_W-1:0]   w_inc_a, w_inc_b;
  logic               w_hit_a, w_hit_b;
  logic               w_have_a, w_have_b;
  logic               w_to_a, w_to_b, w_timeout, w_finish;
  logic [CNT_W-1:0]   w_lat_a, w_lat_b;
  logic               w_pm, w_leak;

  assign w_inc_a  = r_cnt_a + c_cnt_one;
  assign w_inc_b  = r_cnt_b + c_cnt_one;
  assign w_hit_a  = !r_done_a && product_done_a;
  assign w_hit_b  = !r_done_b && product_done_b;
  assign w_have_a = r_done_a || w_hit_a;
  assign w_have_b = r_done_b || w_hit_b;
  assign w_to_a   = !w_have_a && (w_inc_a == c_cnt_max);
  assign w_to_b   = !w_have_b && (w_inc_b == c_cnt_max);
  assign w_timeout = w_to_a || w_to_b;
  assign w_finish  = (w_have_a && w_have_b) || w_timeout;

  // Unlatched counters advance in lockstep with the run, so on timeout an
  // unlatched copy's incremented count is exactly the all-ones value.
  assign w_lat_a = r_done_a ? r_cnt_a : w_inc_a;
  assign w_lat_b = r_done_b ? r_cnt_b : w_inc_b;

`ifdef MULT_PRODUCT_CHECK_EN
  logic [2*WIDTH-1:0] r_prod_a, r_prod_b;
  logic [2*WIDTH-1:0] w_cap_a, w_cap_b;

  assign w_cap_a = r_done_a ? r_prod_a : product_a;
  assign w_cap_b = r_done_b ? r_prod_b : product_b;
  assign w_pm    = !w_timeout && (w_cap_a != w_cap_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod_a <= '0;
      r_prod_b <= '0;
    end else if (r_state == S_RUN) begin
      if (w_hit_a) r_prod_a <= product_a;
      if (w_hit_b) r_prod_b <= product_b;
    end
  end
`else
  logic w_unused_prod;
  assign w_unused_prod = ^{product_a, product_b};
  assign w_pm          = 1'b0;
`endif

  assign w_leak = (w_lat_a != w_lat_b) || w_timeout || w_pm;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_RUN;
      S_RUN:    if (w_finish) w_next = S_REPORT;
      S_REPORT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= S_IDLE;
      r_cnt_a            <= '0;
      r_cnt_b            <= '0;
      r_done_a           <= 1'b0;
      r_done_b           <= 1'b0;
      r_busy             <= 1'b0;
      r_result_valid     <= 1'b0;
      r_latency_a        <= '0;
      r_latency_b        <= '0;
      r_leak             <= 1'b0;
      r_leak_sticky      <= 1'b0;
      r_timeout          <= 1'b0;
      r_product_mismatch <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_busy         <= (w_next != S_IDLE);
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt_a  <= '0;
          r_cnt_b  <= '0;
          r_done_a <= 1'b0;
          r_done_b <= 1'b0;
        end
        S_RUN: begin
          if (!r_done_a) r_cnt_a <= w_inc_a;
          if (!r_done_b) r_cnt_b <= w_inc_b;
          if (w_hit_a) r_done_a <= 1'b1;
          if (w_hit_b) r_done_b <= 1'b1;
          // Results are registered on entry to REPORT so they are visible
          // during the REPORT cycle itself.
          if (w_finish) begin
            r_result_valid     <= 1'b1;
            r_latency_a        <= w_lat_a;
            r_latency_b        <= w_lat_b;
            r_timeout          <= w_timeout;
            r_product_mismatch <= w_pm;
            r_leak             <= w_leak;
            r_leak_sticky      <= r_leak_sticky || w_leak;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy             = r_busy;
  assign result_valid     = r_result_valid;
  assign latency_a        = r_latency_a;
  assign latency_b        = r_latency_b;
  assign leak             = r_leak;
  assign leak_sticky      = r_leak_sticky;
  assign timeout          = r_timeout;
  assign product_mismatch = r_product_mismatch;

endmodule

`default_nettype wire

// File: tb/tb_mult_timing_monitor.sv
// ============================================================================
// Module   : tb_mult_timing_monitor
// Purpose  : Self-checking bench for mult_timing_monitor (CNT_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_timing_monitor;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
  localparam int LMAX  = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic product_done_a = 1'b0;
  logic product_done_b = 1'b0;
  logic [2*WIDTH-1:0] product_a = '0;
  logic [2*WIDTH-1:0] product_b = '0;
  logic busy, result_valid, leak, leak_sticky, timeout, product_mismatch;
  logic [CNT_W-1:0] latency_a, latency_b;

  int vectors = 0;
  int miscompares = 0;

  logic [CNT_W-1:0] m_lat_a = '0, m_lat_b = '0;
  logic m_leak = 1'b0, m_sticky = 1'b0, m_to = 1'b0, m_pm = 1'b0;

  mult_timing_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .product_done_a(product_done_a), .product_done_b(product_done_b),
    .product_a(product_a), .product_b(product_b),
    .busy(busy), .result_valid(result_valid),
    .latency_a(latency_a), .latency_b(latency_b),
    .leak(leak), .leak_sticky(leak_sticky), .timeout(timeout),
    .product_mismatch(product_mismatch)
  );

  always #5 clk = ~clk;

  // Done waveform over RUN cycles 1..20: low before first, level or random after.
  function automatic logic [20:0] mk_done(input int first, input bit glitch);
    logic [20:0] v;
    v = '0;
    if (first > 0)
      for (int k = first; k <= 20; k++)
        v[k] = (k == first) ? 1'b1 : (glitch ? 1'($urandom % 2) : 1'b1);
    return v;
  endfunction

  task automatic run_case(input logic [20:0] ba, input logic [20:0] bb,
                          input logic [7:0] pa, input logic [7:0] pb,
                          input bit noisy);
    int fa, fb, la, lb, last;
    bit to, pm;
    fa = 0; fb = 0;
    for (int k = 1; k <= 20; k++) begin
      if (fa == 0 && ba[k]) fa = k;
      if (fb == 0 && bb[k]) fb = k;
    end
    la = (fa >= 1 && fa <= LMAX) ? fa : LMAX;
    lb = (fb >= 1 && fb <= LMAX) ? fb : LMAX;
    to = !(fa >= 1 && fa <= LMAX) || !(fb >= 1 && fb <= LMAX);
    last = to ? LMAX : ((la > lb) ? la : lb);
`ifdef MULT_PRODUCT_CHECK_EN
    pm = !to && (pa != pb);
`else
    pm = 1'b0;
`endif
    m_lat_a = CNT_W'(la); m_lat_b = CNT_W'(lb);
    m_to = to; m_pm = pm;
    m_leak = (la != lb) || to || pm;
    m_sticky = m_sticky | m_leak;

    @(posedge clk); #1;
    start = 1'b1; product_done_a = 1'b0; product_done_b = 1'b0;
    product_a = pa; product_b = pb;
    for (int k = 1; k <= last + 1; k++) begin
      @(posedge clk); #1;
      vectors++;
      if ({busy, result_valid} !== {1'b1, (k == last + 1)}) begin
        miscompares++;
        $display("FAIL run_flags cycle %0d: busy/valid got %b%b want 1%b", k, busy, result_valid, (k == last + 1));
      end
      if (k == last + 1) begin
        vectors++;
        if ({latency_a, latency_b, leak, leak_sticky, timeout, product_mismatch} !==
            {m_lat_a, m_lat_b, m_leak, m_sticky, m_to, m_pm}) begin
          miscompares++;
          $display("FAIL report: got la=%0d lb=%0d leak=%b sticky=%b to=%b pm=%b want la=%0d lb=%0d leak=%b sticky=%b to=%b pm=%b",
                   latency_a, latency_b, leak, leak_sticky, timeout, product_mismatch,
                   m_lat_a, m_lat_b, m_leak, m_sticky, m_to, m_pm);
        end
      end
      start = noisy ? 1'($urandom % 2) : 1'b0;
      product_done_a = ba[k];
      product_done_b = bb[k];
    end
    @(posedge clk); #1;
    start = 1'b0; product_done_a = 1'b0; product_done_b = 1'b0;
    vectors++;
    if ({busy, result_valid, latency_a, latency_b, leak, leak_sticky, timeout, product_mismatch} !==
        {1'b0, 1'b0, m_lat_a, m_lat_b, m_leak, m_sticky, m_to, m_pm}) begin
      miscompares++;
      $display("FAIL idle_hold: got busy=%b valid=%b la=%0d lb=%0d leak=%b to=%b want busy=0 valid=0 la=%0d lb=%0d leak=%b to=%b",
               busy, result_valid, latency_a, latency_b, leak, timeout, m_lat_a, m_lat_b, m_leak, m_to);
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, result_valid, latency_a, latency_b, leak, leak_sticky, timeout, product_mismatch} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %b want all zero",
               {busy, result_valid, latency_a, latency_b, leak, leak_sticky, timeout, product_mismatch});
    end
    rst = 1'b0;
  endtask

  task automatic test_equal;
    run_case(mk_done(5, 0), mk_done(5, 0), 8'h21, 8'h21, 0);
  endtask

  task automatic test_skewed;
    run_case(mk_done(4, 0), mk_done(7, 0), 8'h10, 8'h10, 0);
    run_case(mk_done(3, 0), mk_done(3, 0), 8'h10, 8'h10, 0);
  endtask

  task automatic test_timeout;
    run_case(mk_done(3, 0), mk_done(0, 0), 8'h05, 8'h05, 0);
    run_case(mk_done(0, 0), mk_done(0, 0), 8'h05, 8'h05, 0);
  endtask

  task automatic test_done_glitch;
    logic [20:0] g;
    g = 21'b1010;
    run_case(g, mk_done(1, 0), 8'h33, 8'h33, 0);
    g = 21'b11010;
    run_case(g, mk_done(3, 0), 8'h33, 8'h33, 0);
  endtask

  task automatic test_ignored_start;
    run_case(mk_done(6, 1), mk_done(6, 1), 8'h44, 8'h44, 1);
    run_case(mk_done(2, 1), mk_done(9, 1), 8'h44, 8'h44, 1);
  endtask

  task automatic test_products;
    run_case(mk_done(4, 0), mk_done(4, 0), 8'h0C, 8'h0D, 0);
    run_case(mk_done(4, 0), mk_done(0, 0), 8'h0C, 8'h0D, 0);
  endtask

  task automatic test_midrun_reset;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, result_valid, latency_a, latency_b, leak, leak_sticky, timeout, product_mismatch} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: got %b want all zero",
               {busy, result_valid, latency_a, latency_b, leak, leak_sticky, timeout, product_mismatch});
    end
    m_lat_a = '0; m_lat_b = '0; m_leak = 0; m_sticky = 0; m_to = 0; m_pm = 0;
    @(posedge clk); #1 rst = 1'b0;
    product_done_a = 1'b1; product_done_b = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      vectors++;
      if ({busy, result_valid} !== 2'b00) begin
        miscompares++;
        $display("FAIL post_reset_quiet cycle %0d: busy/valid got %b%b want 00", k, busy, result_valid);
      end
    end
    product_done_a = 1'b0; product_done_b = 1'b0;
  endtask

  task automatic test_random;
    int fa, fb;
    logic [7:0] pa, pb;
    for (int i = 0; i < 25; i++) begin
      fa = ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 14));
      fb = ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 14));
      if ($urandom % 3 == 0) fb = fa;
      pa = 8'($urandom);
      pb = ($urandom % 2 == 0) ? pa : 8'($urandom);
      run_case(mk_done(fa, 1'($urandom % 2)), mk_done(fb, 1'($urandom % 2)), pa, pb, 1'($urandom % 2));
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_skewed();
    test_timeout();
    test_done_glitch();
    test_ignored_start();
    test_midrun_reset();
    test_products();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_timing_monitor.md
Name: mult_timing_monitor

Overview:
- Downstream checker for the dual-copy constant-time multiplier harness.
- Consumes the start pulse, both copies' done flags and both products.
- Measures each copy's latency in clock cycles and reports a per-run latency-mismatch (timing leak) result, a sticky leak flag and a timeout.
- Replaces the purely combinational done comparison with a cycle-accurate measurement.

Parameters:
- WIDTH, 4, operand width of the monitored multipliers; products are 2*WIDTH bits.
- CNT_W, 8, latency counter width; all-ones (2^CNT_W-1) is the timeout/saturation value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  same start pulse driven to both multiplier copies.
- product_done_a  input  1  done level from copy A.
- product_done_b  input  1  done level from copy B.
- product_a  input  2*WIDTH  product from copy A.
- product_b  input  2*WIDTH  product from copy B.
- busy  output  1  high in RUN and REPORT.
- result_valid  output  1  one-cycle pulse; the result outputs below are valid.
- latency_a  output  CNT_W  measured latency of copy A.
- latency_b  output  CNT_W  measured latency of copy B.
- leak  output  1  this run: latencies differ or timeout.
- leak_sticky  output  1  OR of every reported leak since reset.
- timeout  output  1  this run: a copy did not finish.
- product_mismatch  output  1  see Optional Feature.

Behaviour:
- Reset: all outputs and state registers are 0 (state = IDLE). Reset is asynchronous; asserting it mid-run aborts the run with no report and clears leak_sticky.
- All outputs are registered.
- IDLE: start sampled high moves to RUN. Counters cnt_a and cnt_b, and the done latches, are cleared.
- In IDLE, product_done_* are ignored.
- RUN, per copy x:
  - If not yet latched: cnt_x <= cnt_x+1.
  - If product_done_x is also high this cycle, set latch_x and capture cnt_x+1 as the latency of x.
  - Latency therefore counts RUN cycles up to and including the first cycle done is seen high. Done high in the first RUN cycle gives latency 1.
  - Done is treated as a level; only its first high cycle per run matters. Later toggles are ignored.
- RUN exit:
  - When both copies are latched (including both latching in the same cycle), the next state is REPORT.
  - If either unlatched counter reaches all-ones, set timeout, assign all-ones latency to each unlatched copy, and go to REPORT.
- REPORT (exactly one cycle):
  - result_valid = 1.
  - latency_a and latency_b are updated.
  - leak = (lat_a != lat_b) | timeout.
  - leak_sticky |= leak.
  - The next state is IDLE.
- latency_a, latency_b, leak and timeout hold their values until the next REPORT.
- start is ignored outside IDLE: no restart or queueing. The earliest new run starts on the cycle after REPORT.
- Done-to-report latency: both done at cycle N gives result_valid at N+1. Start at cycle S gives RUN from S+1.

Optional Feature:
- Macro: MULT_PRODUCT_CHECK_EN.
- Defined:
  - The product of each copy is captured on the same edge its done latches.
  - In REPORT, product_mismatch = (captured_a != captured_b), excluding timeout runs.
  - A mismatch also forces leak = 1.
- Undefined: no capture registers; product_mismatch is tied to 0 and product_a/product_b are unused.

Test Plan:
- Equal latency: start at cycle 0; both done rise at cycle 5 -> result_valid at cycle 6; latency_a = latency_b = 5; leak = 0; leak_sticky = 0.
- Skewed latency: done_a at cycle 4, done_b at cycle 7 -> result_valid at cycle 8; latency_a = 4; latency_b = 7; leak = 1; leak_sticky = 1; leak_sticky stays 1 after a following equal-latency run.
- Timeout (CNT_W = 4): done_a at cycle 3, done_b never -> result_valid with latency_a = 3, latency_b = 15, timeout = 1, leak = 1.
- Ignored start and sticky reset: pulse start during RUN and in REPORT -> no restart and latencies unaffected. Assert rst mid-RUN -> all outputs 0 immediately; no result_valid follows.
- Done glitch: done_a high in the first RUN cycle, then low, then high again -> latency_a = 1; done_b at 1 -> leak = 0.
- MULT_PRODUCT_CHECK_EN: products 0x0C vs 0x0D at equal latency 4 -> product_mismatch = 1, leak = 1. With the macro undefined -> product_mismatch = 0, leak = 0.
